uart_tx_frame: RTL
==================

Name: uart_tx_frame

Overview:
- UART transmitter: accepts a parallel byte with a valid strobe and serialises it as start, data LSB-first, optional parity, then stop.
- Sits in the UART TX path, clocked at the TX baud clock: one serial bit per clk cycle, no oversampling.
- Parity convention matches the RX parity checker.
  - par_type=0: even, parity bit = XOR of data.
  - par_type=1: odd, parity bit = XNOR of data.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame.

Ports:
- clk  input  1  TX bit clock; one serial bit per rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- p_data  input  DATA_WIDTH  parallel byte to send; sampled only on accept.
- data_valid  input  1  request to send p_data; single-cycle or held.
- par_en  input  1  1 = insert parity bit; sampled on accept.
- par_type  input  1  0 = even, 1 = odd; sampled on accept.
- tx_out  output  1  serial line; registered; idle high.
- busy  output  1  high while a frame is in progress; registered.

Behaviour:
- Reset (asynchronous, active-low, clock clk): state=IDLE, tx_out=1, busy=0, bit counter=0, data and parity-config holding registers=0.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Accept: in IDLE, when data_valid=1 at a rising edge:
  - latch p_data, par_en, par_type;
  - go to START;
  - at that same edge, tx_out becomes 0 and busy becomes 1.
- Latency: first line change (start bit) is visible 1 cycle after the accepting edge. No combinational path from inputs to outputs.
- START: 1 cycle with tx_out=0, then DATA with the counter at 0.
- DATA: 1 cycle per bit, data[0] first.
  - Counter increments 0..DATA_WIDTH-1.
  - After bit DATA_WIDTH-1: go to PARITY if the latched par_en=1, else STOP.
- PARITY: 1 cycle, tx_out = parity of the latched data per the latched par_type.
  - Parity is computed from the latched copy, not from p_data.
- STOP: 1 cycle with tx_out=1, then IDLE.
  - busy deasserts on the edge leaving STOP; tx_out stays 1.
- Frame length on the line: DATA_WIDTH+2 cycles without parity, DATA_WIDTH+3 with parity (10/11 for 8 bits). busy is high for exactly that many cycles.
- data_valid while busy=1: ignored, no queuing. The holding registers are not updated.
- p_data, par_en, par_type changes mid-frame: no effect on the current frame.
- Back-to-back: data_valid held high leaves IDLE for exactly 1 cycle (tx_out=1, busy=0), then the next frame is accepted. Minimum inter-frame gap is 1 idle bit beyond the stop bit.
- Reset mid-frame: immediately returns to IDLE with tx_out=1 and busy=0. The partial frame is abandoned; the first accept after release starts a clean frame.
- Counter width is clog2(DATA_WIDTH). The counter never wraps within DATA; it clears on entry to DATA.

Decomposition:
- Shared UART package:
  - FSM state encoding (IDLE/START/DATA/PARITY/STOP), shared with RX where its states overlap;
  - START_BIT=0, STOP_BIT=1, IDLE_LEVEL=1;
  - parity-type constants PAR_EVEN=0, PAR_ODD=1, shared with the RX parity checker.
- One sub-module: uart_tx_parity_calc (combinational; latched data + par_type -> parity bit).
- FSM, counter and output mux stay in uart_tx_frame.

Test Plan:
- 0xA5, par_en=1, par_type=0, single-cycle valid -> tx_out from the cycle after accept: 0,1,0,1,0,0,1,0,1,0,1 (start, LSB-first data, parity=0, stop); busy high for exactly 11 cycles.
- 0xA5, par_en=1, par_type=1 -> same sequence with parity bit=1; 0x00 with par_type=1 -> parity=1; 0xFF with par_type=0 -> parity=0.
- 0x3C, par_en=0 -> 0,0,0,1,1,1,1,0,0,1; busy high for 10 cycles; no parity slot.
- Pulse data_valid with 0x55 at cycle 4 of an active 0xA5 frame, and change p_data/par_type mid-frame -> 0xA5 frame unaltered; 0x55 never sent.
- data_valid held high with 0x81 then 0x7E, par_en=0 -> frames separated by exactly one idle-high cycle with busy=0; both frames are bit-exact.
- Assert rst_n low during DATA bit 3 -> tx_out=1 and busy=0 immediately (asynchronously); after release, 0xC3 with par_en=1, par_type=0 sends a clean 11-cycle frame with parity=0.

Source files
------------

// File: rtl/uart_tx_frame_pkg.sv
// rtl/uart_tx_frame_pkg.sv - shared UART state encoding, line levels and parity constants
package uart_tx_frame_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_parity_calc.sv
// rtl/uart_tx_parity_calc.sv - combinational parity bit for the latched TX data word
module uart_tx_parity_calc
  import uart_tx_frame_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_type,
  output logic                  parity
);

  // Even: bit makes the total count of ones even; odd inverts it.
  assign parity = (par_type == PAR_ODD) ? ~(^data) : (^data);

endmodule

// File: rtl/uart_tx_frame.sv
// rtl/uart_tx_frame.sv - UART transmitter: start, LSB-first data, optional parity, stop
module uart_tx_frame
  import uart_tx_frame_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  par_en,
  input  logic                  par_type,
  output logic                  tx_out,
  output logic                  busy
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  uart_state_e           state_q, state_n;
  logic [CNT_W-1:0]      cnt_q, cnt_n;
  logic [DATA_WIDTH-1:0] data_q, data_n;
  logic                  par_en_q, par_en_n;
  logic                  par_type_q, par_type_n;
  logic                  tx_q, tx_n;
  logic                  busy_q, busy_n;
  logic                  parity_bit;

  uart_tx_parity_calc #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_parity (
    .data    (data_q),
    .par_type(par_type_q),
    .parity  (parity_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      data_q     <= '0;
      par_en_q   <= 1'b0;
      par_type_q <= PAR_EVEN;
      tx_q       <= IDLE_LEVEL;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_n;
      cnt_q      <= cnt_n;
      data_q     <= data_n;
      par_en_q   <= par_en_n;
      par_type_q <= par_type_n;
      tx_q       <= tx_n;
      busy_q     <= busy_n;
    end
  end

  always_comb begin
    state_n    = state_q;
    cnt_n      = cnt_q;
    data_n     = data_q;
    par_en_n   = par_en_q;
    par_type_n = par_type_q;
    case (state_q)
      IDLE: begin
        if (data_valid) begin
          state_n    = START;
          data_n     = p_data;
          par_en_n   = par_en;
          par_type_n = par_type;
        end
      end
      START: begin
        state_n = DATA;
        cnt_n   = '0;
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          state_n = par_en_q ? PARITY : STOP;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      PARITY:  state_n = STOP;
      STOP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the line register changes
  // on the same edge that enters each state.
  always_comb begin
    tx_n   = IDLE_LEVEL;
    busy_n = (state_n != IDLE);
    case (state_n)
      START:   tx_n = START_BIT;
      DATA:    tx_n = data_q[cnt_n];
      PARITY:  tx_n = parity_bit;
      STOP:    tx_n = STOP_BIT;
      default: tx_n = IDLE_LEVEL;
    endcase
  end

  assign tx_out = tx_q;
  assign busy   = busy_q;

endmodule
